// File: rtl/mem_io_bus_if.sv
// Processor-side memory bus between the multicycle core and mem_io_bus.
// The core drives ADDR, DOUT and W from its own registers; DIN comes back
// registered, one clock after the ADDR it belongs to.
interface mem_io_bus_if;
  // Handshake semantics: there is no valid/ready pair on this bus. Every
  // rising edge is a transfer. A read of ADDR is always performed and its
  // data appears on DIN one clock later. When W=1 at an edge, DOUT is
  // committed to ADDR on that same edge. The slave never stalls.
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;

  modport master (output ADDR, output DOUT, output W, input DIN);
  modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/mem_io_bus.sv
// mem_io_bus: memory-mapped RAM, LED register, switch port and prescaled
// countdown timer behind the 16-bit multicycle processor.
// Map (ADDR[15:12]): 0 RAM, 1 LEDR, 2 timer (LOAD/CTRL/STATUS/COUNT),
// 3 SW, 4 HEX (only when MEM_IO_HEX_EN is defined), others read 0.
// Optional feature macro: MEM_IO_HEX_EN adds the HEX register and port.
module mem_io_bus #(
  parameter int    RAM_AW    = 8,
  parameter int    SW_W      = 10,
  parameter int    PRESCALE  = 50000,
  parameter string INIT_FILE = "inst_mem.mif"
) (
  input  logic            Clock,
  input  logic            Reset,
  mem_io_bus_if.slave     bus,
  input  logic [SW_W-1:0] SW,
  output logic [SW_W-1:0] LEDR,
`ifdef MEM_IO_HEX_EN
  output logic [15:0]     HEX,
`endif
  output logic            TIRQ
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  localparam logic [3:0] R_RAM   = 4'h0;
  localparam logic [3:0] R_LED   = 4'h1;
  localparam logic [3:0] R_TMR   = 4'h2;
  localparam logic [3:0] R_SW    = 4'h3;
  localparam logic [3:0] R_HEX   = 4'h4;
  localparam logic [3:0] R_UNMAP = 4'hF;

  // Address decode
  logic [3:0]        region;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        tmr_sel;
  logic              unused_addr;

  assign region      = bus.ADDR[15:12];
  assign ram_idx     = bus.ADDR[RAM_AW-1:0];
  assign tmr_sel     = bus.ADDR[1:0];
  // Bits between the RAM index and the region field are don't-care (RAM aliases).
  assign unused_addr = ^bus.ADDR[11:2];

  logic wr_ram, wr_led, wr_load, wr_ctrl, wr_status, wr_hex;
  assign wr_ram    = bus.W && (region == R_RAM);
  assign wr_led    = bus.W && (region == R_LED);
  assign wr_load   = bus.W && (region == R_TMR) && (tmr_sel == 2'd0);
  assign wr_ctrl   = bus.W && (region == R_TMR) && (tmr_sel == 2'd1);
  assign wr_status = bus.W && (region == R_TMR) && (tmr_sel == 2'd2);
  assign wr_hex    = bus.W && (region == R_HEX);

  // RAM: write and read on the same edge; the read sees the old word.
  (* ram_init_file = INIT_FILE *) logic [15:0] ram [2**RAM_AW];
  logic [15:0] ram_q;

  // RAM port kept free of reset so it maps onto block memory
  always_ff @(posedge Clock) begin
    if (wr_ram) ram[ram_idx] <= bus.DOUT;
    ram_q <= ram[ram_idx];
  end

  // Switch synchroniser
  logic [SW_W-1:0] sw_s1, sw_s2;

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
    end
  end

  // LED register (and optional HEX register)
  logic [15:0] hex_q;

  // LED/HEX register writes
  always_ff @(posedge Clock) begin
    if (Reset) begin
      LEDR  <= '0;
      hex_q <= '0;
    end else begin
      if (wr_led) LEDR <= bus.DOUT[SW_W-1:0];
      if (wr_hex) hex_q <= bus.DOUT;
    end
  end

`ifdef MEM_IO_HEX_EN
  assign HEX = hex_q;
`endif

  // Timer state
  logic [15:0] t_load, t_count, t_presc;
  logic        t_en, t_auto, t_exp;
  logic        tick;

  assign tick = t_en && (t_presc == PRE_MAX);

  // Timer: prescaler, countdown and expiry. A LOAD write discards a
  // coincident tick, a CTRL write overrides the tick's auto-disable,
  // and an expiry beats a coincident STATUS clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      t_load  <= '0;
      t_count <= '0;
      t_presc <= '0;
      t_en    <= 1'b0;
      t_auto  <= 1'b0;
      t_exp   <= 1'b0;
    end else begin
      if (wr_status) t_exp <= 1'b0;
      if (t_en) t_presc <= tick ? 16'd0 : t_presc + 16'd1;
      if (wr_load) begin
        t_load  <= bus.DOUT;
        t_count <= bus.DOUT;
        t_presc <= '0;
      end else if (tick) begin
        if (t_count > 16'd1) begin
          t_count <= t_count - 16'd1;
        end else begin
          t_exp <= 1'b1;
          if (t_auto) begin
            t_count <= t_load;
          end else begin
            t_count <= '0;
            t_en    <= 1'b0;
          end
        end
      end
      if (wr_ctrl) begin
        t_en   <= bus.DOUT[0];
        t_auto <= bus.DOUT[1];
      end
    end
  end

  assign TIRQ = t_exp;

  // Read mux for the non-RAM regions
  logic [15:0] sw_ext, led_ext, rd_periph;

  // Zero-extend the SW_W-wide ports to the 16-bit data bus
  always_comb begin
    sw_ext  = '0;
    led_ext = '0;
    sw_ext[SW_W-1:0]  = sw_s2;
    led_ext[SW_W-1:0] = LEDR;
  end

  // Select peripheral read data from the current address
  always_comb begin
    rd_periph = '0;
    case (region)
      R_LED: rd_periph = led_ext;
      R_SW:  rd_periph = sw_ext;
      R_TMR: begin
        case (tmr_sel)
          2'd0:    rd_periph = t_load;
          2'd1:    rd_periph = {14'b0, t_auto, t_en};
          2'd2:    rd_periph = {15'b0, t_exp};
          default: rd_periph = t_count;
        endcase
      end
`ifdef MEM_IO_HEX_EN
      R_HEX: rd_periph = hex_q;
`endif
      default: rd_periph = '0;
    endcase
  end

  // Registered peripheral data and region; reset parks the region on an
  // unmapped value so DIN reads 0 out of reset.
  logic [15:0] periph_q;
  logic [3:0]  region_q;

  // Register read data alongside the RAM output
  always_ff @(posedge Clock) begin
    if (Reset) begin
      periph_q <= '0;
      region_q <= R_UNMAP;
    end else begin
      periph_q <= rd_periph;
      region_q <= region;
    end
  end

  assign bus.DIN = (region_q == R_RAM) ? ram_q : periph_q;

endmodule

// File: tb/tb_mem_io_bus.sv
// Directed bench for mem_io_bus with PRESCALE=4. Inputs change 1 ns after
// each rising edge; outputs are sampled at the same point.
module tb_mem_io_bus;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  SW    = '0;
  logic [9:0]  LEDR;
  logic        TIRQ;
`ifdef MEM_IO_HEX_EN
  logic [15:0] HEX;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_io_bus_if bus ();

  mem_io_bus #(
    .RAM_AW   (8),
    .SW_W     (10),
    .PRESCALE (4),
    .INIT_FILE("inst_mem.mif")
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus),
    .SW    (SW),
    .LEDR  (LEDR),
`ifdef MEM_IO_HEX_EN
    .HEX   (HEX),
`endif
    .TIRQ  (TIRQ)
  );

  // Clock
  always #5 Clock = ~Clock;

  // Driver tasks
  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    bus.ADDR = a;
    bus.DOUT = d;
    bus.W    = 1'b1;
    cycle();
    bus.W    = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a);
    bus.ADDR = a;
    bus.W    = 1'b0;
    cycle();
  endtask

  // Scenarios
  task automatic test_reset();
    bus.ADDR = 16'h7000;
    bus.DOUT = 16'h0000;
    bus.W    = 1'b0;
    Reset    = 1'b1;
    repeat (2) cycle();
    Reset = 1'b0;
    cycle();
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL reset_din: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    if (LEDR !== 10'h000) begin
      $display("FAIL reset_ledr: got %h want %h", LEDR, 10'h000); n_fail++;
    end
    n_checks++;
    if (TIRQ !== 1'b0) begin
      $display("FAIL reset_tirq: got %b want 0", TIRQ); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_ram();
    do_write(16'h0005, 16'hBEEF);
    do_read(16'h7000);
    bus.ADDR = 16'h0005;
    #1;
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL ram_latency_early: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    cycle();
    if (bus.DIN !== 16'hBEEF) begin
      $display("FAIL ram_read: got %h want %h", bus.DIN, 16'hBEEF); n_fail++;
    end
    n_checks++;
    do_read(16'h0105);
    if (bus.DIN !== 16'hBEEF) begin
      $display("FAIL ram_alias: got %h want %h", bus.DIN, 16'hBEEF); n_fail++;
    end
    n_checks++;
    // Read-during-write to the same word returns the old contents
    do_write(16'h0007, 16'h1111);
    do_write(16'h0007, 16'h2222);
    if (bus.DIN !== 16'h1111) begin
      $display("FAIL ram_rdw_old: got %h want %h", bus.DIN, 16'h1111); n_fail++;
    end
    n_checks++;
    do_read(16'h0007);
    if (bus.DIN !== 16'h2222) begin
      $display("FAIL ram_rdw_new: got %h want %h", bus.DIN, 16'h2222); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_led_sw();
    do_write(16'h1000, 16'h03FF);
    if (LEDR !== 10'h3FF) begin
      $display("FAIL led_out: got %h want %h", LEDR, 10'h3FF); n_fail++;
    end
    n_checks++;
    do_read(16'h1000);
    if (bus.DIN !== 16'h03FF) begin
      $display("FAIL led_read: got %h want %h", bus.DIN, 16'h03FF); n_fail++;
    end
    n_checks++;
    SW = 10'h155;
    do_read(16'h3000);
    do_read(16'h3000);
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL sw_sync_delay: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    do_read(16'h3000);
    if (bus.DIN !== 16'h0155) begin
      $display("FAIL sw_read: got %h want %h", bus.DIN, 16'h0155); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_timer_oneshot();
    do_write(16'h2000, 16'd3);
    do_write(16'h2001, 16'd1);
    repeat (11) cycle();
    if (TIRQ !== 1'b0) begin
      $display("FAIL oneshot_early: got %b want 0", TIRQ); n_fail++;
    end
    n_checks++;
    cycle();
    if (TIRQ !== 1'b1) begin
      $display("FAIL oneshot_expire: got %b want 1", TIRQ); n_fail++;
    end
    n_checks++;
    do_read(16'h2003);
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL oneshot_count: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    do_read(16'h2001);
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL oneshot_ctrl: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    do_read(16'h2002);
    if (bus.DIN !== 16'h0001) begin
      $display("FAIL oneshot_status: got %h want %h", bus.DIN, 16'h0001); n_fail++;
    end
    n_checks++;
    do_write(16'h2002, 16'h0000);
    if (TIRQ !== 1'b0) begin
      $display("FAIL status_clear: got %b want 0", TIRQ); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_timer_auto();
    do_write(16'h2000, 16'd2);
    do_write(16'h2001, 16'd3);       // edge e0
    repeat (7) cycle();              // e1..e7
    if (TIRQ !== 1'b0) begin
      $display("FAIL auto_early: got %b want 0", TIRQ); n_fail++;
    end
    n_checks++;
    cycle();                         // e8: expiry
    if (TIRQ !== 1'b1) begin
      $display("FAIL auto_expire: got %b want 1", TIRQ); n_fail++;
    end
    n_checks++;
    do_read(16'h2003);               // e9 shows COUNT after e8
    if (bus.DIN !== 16'd2) begin
      $display("FAIL auto_reload: got %h want %h", bus.DIN, 16'd2); n_fail++;
    end
    n_checks++;
    repeat (2) cycle();              // e10, e11
    do_write(16'h2002, 16'h0000);    // e12: tick decrements, clear EXP
    if (TIRQ !== 1'b0) begin
      $display("FAIL auto_clear: got %b want 0", TIRQ); n_fail++;
    end
    n_checks++;
    repeat (3) cycle();              // e13..e15
    do_write(16'h2002, 16'h0000);    // e16: clear coincides with expiry
    if (TIRQ !== 1'b1) begin
      $display("FAIL clear_vs_expire: got %b want 1", TIRQ); n_fail++;
    end
    n_checks++;
    do_write(16'h2001, 16'd0);
    do_write(16'h2002, 16'h0000);
  endtask

  task automatic test_timer_zero_load();
    do_write(16'h2000, 16'd0);
    do_write(16'h2001, 16'd1);
    repeat (3) cycle();
    if (TIRQ !== 1'b0) begin
      $display("FAIL zero_load_early: got %b want 0", TIRQ); n_fail++;
    end
    n_checks++;
    cycle();
    if (TIRQ !== 1'b1) begin
      $display("FAIL zero_load_expire: got %b want 1", TIRQ); n_fail++;
    end
    n_checks++;
    do_write(16'h2002, 16'h0000);
  endtask

  task automatic test_load_vs_tick_and_reset();
    do_write(16'h2000, 16'd2);
    do_write(16'h2001, 16'd1);       // e0
    repeat (3) cycle();              // e1..e3
    do_write(16'h2000, 16'd5);       // e4: tick discarded
    do_read(16'h2003);
    if (bus.DIN !== 16'd5) begin
      $display("FAIL load_vs_tick: got %h want %h", bus.DIN, 16'd5); n_fail++;
    end
    n_checks++;
    bus.ADDR = 16'h0005;
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL midreset_din: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    if (LEDR !== 10'h000) begin
      $display("FAIL midreset_ledr: got %h want %h", LEDR, 10'h000); n_fail++;
    end
    n_checks++;
    do_read(16'h2003);
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL midreset_count: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    do_read(16'h2001);
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL midreset_ctrl: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    repeat (8) cycle();
    do_read(16'h2003);
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL midreset_stopped: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    do_read(16'h0005);
    if (bus.DIN !== 16'hBEEF) begin
      $display("FAIL midreset_ram: got %h want %h", bus.DIN, 16'hBEEF); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_unmapped_hex();
    do_write(16'h7000, 16'hFFFF);
    do_read(16'h7000);
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL unmapped_read: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
    do_write(16'h4000, 16'h1234);
    do_read(16'h4000);
`ifdef MEM_IO_HEX_EN
    if (HEX !== 16'h1234) begin
      $display("FAIL hex_out: got %h want %h", HEX, 16'h1234); n_fail++;
    end
    n_checks++;
    if (bus.DIN !== 16'h1234) begin
      $display("FAIL hex_read: got %h want %h", bus.DIN, 16'h1234); n_fail++;
    end
    n_checks++;
`else
    if (bus.DIN !== 16'h0000) begin
      $display("FAIL hex_unmapped: got %h want %h", bus.DIN, 16'h0000); n_fail++;
    end
    n_checks++;
`endif
  endtask

  // Sequence and report
  initial begin
    bus.ADDR = 16'h7000;
    bus.DOUT = 16'h0000;
    bus.W    = 1'b0;
    test_reset();
    test_ram();
    test_led_sw();
    test_timer_oneshot();
    test_timer_auto();
    test_timer_zero_load();
    test_load_vs_tick_and_reset();
    test_unmapped_hex();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
